// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 round controller.
// Holds the state codes seen by the datapath, the round limits and the IV.
package sha256_pkg;

    // State codes presented to the compression datapath
    localparam logic [1:0] ST_IDLE        = 2'd0;
    localparam logic [1:0] ST_ROUND0TO15  = 2'd1;
    localparam logic [1:0] ST_ROUND16TO63 = 2'd2;
    localparam logic [1:0] ST_ROUND64     = 2'd3;

    // Round limits: last message-fed round, last scheduled round, finalize round
    localparam logic [6:0] ROUND_MSG_LAST   = 7'd15;
    localparam logic [6:0] ROUND_SCHED_LAST = 7'd63;
    localparam logic [6:0] ROUND_FINAL      = 7'd64;

    // SHA-256 initial hash value H0..H7
    localparam logic [31:0] IV_H0 = 32'h6a09e667;
    localparam logic [31:0] IV_H1 = 32'hbb67ae85;
    localparam logic [31:0] IV_H2 = 32'h3c6ef372;
    localparam logic [31:0] IV_H3 = 32'ha54ff53a;
    localparam logic [31:0] IV_H4 = 32'h510e527f;
    localparam logic [31:0] IV_H5 = 32'h9b05688c;
    localparam logic [31:0] IV_H6 = 32'h1f83d9ab;
    localparam logic [31:0] IV_H7 = 32'h5be0cd19;

    // Packed IV with H0 in the top word, matching the digest layout
    localparam logic [255:0] IV_ALL = {IV_H0, IV_H1, IV_H2, IV_H3,
                                       IV_H4, IV_H5, IV_H6, IV_H7};

endpackage

// File: rtl/sha256_round_ctrl.sv
// SHA-256 round controller.
// Accepts one 512-bit block at a time, walks the datapath through 64 rounds
// plus a finalize round, keeps the chaining value H and publishes the digest
// of the last block of each message through a valid/ready handshake.
module sha256_round_ctrl
    import sha256_pkg::*;
(
    input  logic         CLK,
    input  logic         RST,
    input  logic         blk_valid_in,
    input  logic         blk_first_in,
    input  logic         blk_last_in,
    output logic         blk_ready_out,
    output logic         comp_start_out,
    output logic [1:0]   fsm_state_out,
    output logic [6:0]   round_out,
    output logic         msg_req_out,
    output logic [31:0]  chain0_out,
    output logic [31:0]  chain1_out,
    output logic [31:0]  chain2_out,
    output logic [31:0]  chain3_out,
    output logic [31:0]  chain4_out,
    output logic [31:0]  chain5_out,
    output logic [31:0]  chain6_out,
    output logic [31:0]  chain7_out,
    input  logic [31:0]  comp0_in,
    input  logic [31:0]  comp1_in,
    input  logic [31:0]  comp2_in,
    input  logic [31:0]  comp3_in,
    input  logic [31:0]  comp4_in,
    input  logic [31:0]  comp5_in,
    input  logic [31:0]  comp6_in,
    input  logic [31:0]  comp7_in,
    input  logic         comp_valid_in,
    output logic [255:0] digest_out,
    output logic         digest_valid_out,
    input  logic         digest_ready_in
);

    logic [1:0]   state_q, state_d;
    logic [6:0]   round_q, round_d;
    logic [255:0] h_q, h_d;
    logic         last_q, last_d;
    logic         err_q, err_d;
    logic         dvalid_q, dvalid_d;

    logic         accept;
    logic [255:0] chain_w;
    logic [255:0] comp_w;
    logic         err_unused;

    // Ready only in IDLE and only if any pending digest is gone or leaving now
    assign blk_ready_out  = (state_q == ST_IDLE) && (!dvalid_q || digest_ready_in);
    assign accept         = blk_valid_in && blk_ready_out;
    assign comp_start_out = accept;

    assign fsm_state_out    = state_q;
    assign round_out        = round_q;
    assign msg_req_out      = (state_q == ST_ROUND0TO15);
    assign digest_out       = h_q;
    assign digest_valid_out = dvalid_q;

    // The datapath loads the chain at the accept edge, so a first block sees IV directly
    assign chain_w    = ((state_q == ST_IDLE) && blk_first_in) ? IV_ALL : h_q;
    assign chain0_out = chain_w[255:224];
    assign chain1_out = chain_w[223:192];
    assign chain2_out = chain_w[191:160];
    assign chain3_out = chain_w[159:128];
    assign chain4_out = chain_w[127:96];
    assign chain5_out = chain_w[95:64];
    assign chain6_out = chain_w[63:32];
    assign chain7_out = chain_w[31:0];

    assign comp_w = {comp0_in, comp1_in, comp2_in, comp3_in,
                     comp4_in, comp5_in, comp6_in, comp7_in};

    // The sticky error has no port; it is kept for debug probes only
    assign err_unused = err_q;

    // Round sequencing: 16 message rounds, 48 scheduled rounds, one finalize round
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        case (state_q)
            ST_IDLE: begin
                round_d = '0;
                if (accept) begin
                    state_d = ST_ROUND0TO15;
                end
            end
            ST_ROUND0TO15: begin
                round_d = round_q + 7'd1;
                if (round_q == ROUND_MSG_LAST) begin
                    state_d = ST_ROUND16TO63;
                end
            end
            ST_ROUND16TO63: begin
                if (round_q == ROUND_SCHED_LAST) begin
                    state_d = ST_ROUND64;
                    round_d = ROUND_FINAL;
                end else begin
                    round_d = round_q + 7'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                round_d = '0;
            end
        endcase
    end

    // Chaining value, message flags and digest handshake
    always_comb begin
        h_d      = h_q;
        last_d   = last_q;
        err_d    = err_q;
        dvalid_d = dvalid_q;
        if (dvalid_q && digest_ready_in) begin
            dvalid_d = 1'b0;
        end
        if (accept) begin
            last_d = blk_last_in;
            if (blk_first_in) begin
                h_d = IV_ALL;
            end
        end
        if (state_q == ST_ROUND64) begin
            if (comp_valid_in) begin
                h_d = comp_w;
            end else begin
                err_d = 1'b1;
            end
            if (last_q) begin
                dvalid_d = 1'b1;
            end
        end
    end

    // State registers; reset abandons any block in flight
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= ST_IDLE;
            round_q  <= '0;
            h_q      <= IV_ALL;
            last_q   <= 1'b0;
            err_q    <= 1'b0;
            dvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            round_q  <= round_d;
            h_q      <= h_d;
            last_q   <= last_d;
            err_q    <= err_d;
            dvalid_q <= dvalid_d;
        end
    end

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Testbench for sha256_round_ctrl.
// A behavioural compression datapath closes the loop around the controller;
// expected digests come from a whole-block SHA-256 reference function and
// from published test vectors.
module tb_sha256_round_ctrl;

    logic         CLK;
    logic         RST;
    logic         blk_valid_in;
    logic         blk_first_in;
    logic         blk_last_in;
    logic         blk_ready_out;
    logic         comp_start_out;
    logic [1:0]   fsm_state_out;
    logic [6:0]   round_out;
    logic         msg_req_out;
    logic [31:0]  chain0_out, chain1_out, chain2_out, chain3_out;
    logic [31:0]  chain4_out, chain5_out, chain6_out, chain7_out;
    logic [31:0]  comp0_in, comp1_in, comp2_in, comp3_in;
    logic [31:0]  comp4_in, comp5_in, comp6_in, comp7_in;
    logic         comp_valid_in;
    logic [255:0] digest_out;
    logic         digest_valid_out;
    logic         digest_ready_in;

    int assertCount = 0;
    int failCount   = 0;

    localparam logic [255:0] TB_IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [255:0] ABC_DIGEST   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] EMPTY_DIGEST = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
    localparam logic [255:0] TWO_DIGEST   = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

    localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'd0, 32'd24};
    localparam logic [511:0] EMPTY_BLK = {32'h80000000, 448'd0, 32'd0};
    localparam logic [511:0] TWO_BLK1  = 512'h61626364_62636465_63646566_64656667_65666768_66676869_6768696a_68696a6b_696a6b6c_6a6b6c6d_6b6c6d6e_6c6d6e6f_6d6e6f70_6e6f7071_80000000_00000000;
    localparam logic [511:0] TWO_BLK2  = {480'd0, 32'h000001c0};

    localparam logic [31:0] K_TAB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // Reference model state: chaining value and pending-digest flag
    logic [255:0] hModel;
    logic         modelPending;

    // Datapath model state
    logic [255:0] dpState;
    logic [31:0]  dpW [64];
    logic         dpGood;
    logic [511:0] curBlock;
    logic [255:0] chainAll;

    sha256_round_ctrl dut (
        .CLK              (CLK),
        .RST              (RST),
        .blk_valid_in     (blk_valid_in),
        .blk_first_in     (blk_first_in),
        .blk_last_in      (blk_last_in),
        .blk_ready_out    (blk_ready_out),
        .comp_start_out   (comp_start_out),
        .fsm_state_out    (fsm_state_out),
        .round_out        (round_out),
        .msg_req_out      (msg_req_out),
        .chain0_out       (chain0_out),
        .chain1_out       (chain1_out),
        .chain2_out       (chain2_out),
        .chain3_out       (chain3_out),
        .chain4_out       (chain4_out),
        .chain5_out       (chain5_out),
        .chain6_out       (chain6_out),
        .chain7_out       (chain7_out),
        .comp0_in         (comp0_in),
        .comp1_in         (comp1_in),
        .comp2_in         (comp2_in),
        .comp3_in         (comp3_in),
        .comp4_in         (comp4_in),
        .comp5_in         (comp5_in),
        .comp6_in         (comp6_in),
        .comp7_in         (comp7_in),
        .comp_valid_in    (comp_valid_in),
        .digest_out       (digest_out),
        .digest_valid_out (digest_valid_out),
        .digest_ready_in  (digest_ready_in)
    );

    // Free-running clock
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    assign chainAll = {chain0_out, chain1_out, chain2_out, chain3_out,
                       chain4_out, chain5_out, chain6_out, chain7_out};

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [255:0] roundStep(input logic [255:0] s, input logic [31:0] w, input logic [31:0] k);
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        {a, b, c, d, e, f, g, h} = s;
        t1 = h + bsig1(e) + ((e & f) ^ (~e & g)) + k + w;
        t2 = bsig0(a) + ((a & b) ^ (a & c) ^ (b & c));
        return {t1 + t2, a, b, c, d + t1, e, f, g};
    endfunction

    // Whole-block SHA-256 compression used as the golden model
    function automatic logic [255:0] sha256Compress(input logic [255:0] hIn, input logic [511:0] blk);
        logic [31:0]  w [64];
        logic [255:0] s;
        logic [255:0] hOut;
        for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++) w[t] = ssig1(w[t-2]) + w[t-7] + ssig0(w[t-15]) + w[t-16];
        s = hIn;
        for (int t = 0; t < 64; t++) s = roundStep(s, w[t], K_TAB[t]);
        for (int i = 0; i < 8; i++) hOut[255 - 32*i -: 32] = hIn[255 - 32*i -: 32] + s[255 - 32*i -: 32];
        return hOut;
    endfunction

    function automatic logic [31:0] msgWord(input int r);
        return curBlock[511 - 32*r -: 32];
    endfunction

    function automatic logic [31:0] schedWord(input int r);
        return ssig1(dpW[r-2]) + dpW[r-7] + ssig0(dpW[r-15]) + dpW[r-16];
    endfunction

    function automatic logic [511:0] randBlock();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
        return b;
    endfunction

    // Compression datapath: loads the chain on start, performs one round per cycle
    always @(posedge CLK) begin
        if (comp_start_out) begin
            dpState <= chainAll;
        end else if (fsm_state_out == 2'd1) begin
            dpW[round_out[5:0]] <= msgWord(int'(round_out));
            dpState <= roundStep(dpState, msgWord(int'(round_out)), K_TAB[round_out[5:0]]);
        end else if (fsm_state_out == 2'd2) begin
            dpW[round_out[5:0]] <= schedWord(int'(round_out));
            dpState <= roundStep(dpState, schedWord(int'(round_out)), K_TAB[round_out[5:0]]);
        end
    end

    assign comp0_in = chain0_out + dpState[255:224];
    assign comp1_in = chain1_out + dpState[223:192];
    assign comp2_in = chain2_out + dpState[191:160];
    assign comp3_in = chain3_out + dpState[159:128];
    assign comp4_in = chain4_out + dpState[127:96];
    assign comp5_in = chain5_out + dpState[95:64];
    assign comp6_in = chain6_out + dpState[63:32];
    assign comp7_in = chain7_out + dpState[31:0];
    assign comp_valid_in = (fsm_state_out == 2'd3) && dpGood;

    task automatic checkOutput(input string tag, input logic [255:0] actual, input logic [255:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Drives one block in the current cycle and follows it through T+66
    task automatic applyStimulus(input logic [511:0] blk, input logic first, input logic last);
        logic [255:0] base;
        int msgCount;
        int expState;
        int expRound;
        curBlock        = blk;
        blk_valid_in    = 1'b1;
        blk_first_in    = first;
        blk_last_in     = last;
        digest_ready_in = 1'b1;
        #1;
        checkOutput("readyAtT", 256'(blk_ready_out), 256'(1));
        checkOutput("startAtT", 256'(comp_start_out), 256'(1));
        checkOutput("stateAtT", 256'(fsm_state_out), 256'(0));
        checkOutput("roundAtT", 256'(round_out), 256'(0));
        base = first ? TB_IV : hModel;
        checkOutput("chainAtT", chainAll, base);
        hModel = dpGood ? sha256Compress(base, blk) : base;
        msgCount = 0;
        for (int k = 1; k <= 66; k++) begin
            @(negedge CLK);
            if (k < 66) begin
                blk_valid_in    = 1'($urandom_range(0, 1));
                blk_first_in    = 1'($urandom_range(0, 1));
                blk_last_in     = 1'($urandom_range(0, 1));
                digest_ready_in = 1'($urandom_range(0, 1));
            end else begin
                blk_valid_in    = 1'b0;
                blk_first_in    = 1'b0;
                blk_last_in     = 1'b0;
                digest_ready_in = 1'b0;
            end
            #1;
            expState = (k <= 16) ? 1 : (k <= 64) ? 2 : (k == 65) ? 3 : 0;
            expRound = (k <= 64) ? k - 1 : (k == 65) ? 64 : 0;
            checkOutput("traceState", 256'(fsm_state_out), 256'(expState));
            checkOutput("traceRound", 256'(round_out), 256'(expRound));
            if (msg_req_out) msgCount++;
            if (k < 66) begin
                checkOutput("busyNotReady", 256'(blk_ready_out), 256'(0));
                checkOutput("busyNoStart", 256'(comp_start_out), 256'(0));
            end
            if (k == 1)  checkOutput("digestClearedAtT1", 256'(digest_valid_out), 256'(0));
            if (k == 32) checkOutput("chainStable", chainAll, base);
            if (k == 65) checkOutput("noDigestAtT65", 256'(digest_valid_out), 256'(0));
        end
        checkOutput("msgReqCycles", 256'(msgCount), 256'(16));
        checkOutput("digestValidAtT66", 256'(digest_valid_out), 256'(last));
        checkOutput("chainAfterBlock", chainAll, hModel);
        if (last) checkOutput("digestValue", digest_out, hModel);
        modelPending = last;
    endtask

    // Holds off the consumer while offering blocks that must be refused
    task automatic holdDigest(input int holdCycles);
        for (int c = 0; c < holdCycles; c++) begin
            blk_valid_in    = 1'b1;
            blk_first_in    = 1'($urandom_range(0, 1));
            digest_ready_in = 1'b0;
            #1;
            checkOutput("holdNotReady", 256'(blk_ready_out), 256'(0));
            checkOutput("holdNoStart", 256'(comp_start_out), 256'(0));
            checkOutput("holdValid", 256'(digest_valid_out), 256'(1));
            checkOutput("holdDigest", digest_out, hModel);
            @(negedge CLK);
        end
        blk_valid_in = 1'b0;
        blk_first_in = 1'b0;
    endtask

    task automatic releaseDigest();
        blk_valid_in    = 1'b0;
        digest_ready_in = 1'b1;
        #1;
        checkOutput("releaseValid", 256'(digest_valid_out), 256'(1));
        @(negedge CLK);
        digest_ready_in = 1'b0;
        #1;
        checkOutput("releaseCleared", 256'(digest_valid_out), 256'(0));
        checkOutput("releaseKeepsH", digest_out, hModel);
        modelPending = 1'b0;
        @(negedge CLK);
    endtask

    task automatic idleCycles(input int n);
        for (int c = 0; c < n; c++) begin
            blk_valid_in    = 1'b0;
            digest_ready_in = 1'b0;
            blk_first_in    = 1'($urandom_range(0, 1));
            #1;
            checkOutput("idleState", 256'(fsm_state_out), 256'(0));
            checkOutput("idleRound", 256'(round_out), 256'(0));
            checkOutput("idleMsgReq", 256'(msg_req_out), 256'(0));
            checkOutput("idleReady", 256'(blk_ready_out), 256'(!modelPending));
            checkOutput("idleDigestValid", 256'(digest_valid_out), 256'(modelPending));
            checkOutput("idleChain", chainAll, blk_first_in ? TB_IV : hModel);
            @(negedge CLK);
        end
        blk_first_in = 1'b0;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "Ready"}, 256'(blk_ready_out), 256'(1));
        checkOutput({tag, "Start"}, 256'(comp_start_out), 256'(0));
        checkOutput({tag, "MsgReq"}, 256'(msg_req_out), 256'(0));
        checkOutput({tag, "State"}, 256'(fsm_state_out), 256'(0));
        checkOutput({tag, "Round"}, 256'(round_out), 256'(0));
        checkOutput({tag, "DigestValid"}, 256'(digest_valid_out), 256'(0));
        checkOutput({tag, "Digest"}, digest_out, TB_IV);
        checkOutput({tag, "Chain"}, chainAll, TB_IV);
        checkOutput({tag, "Err"}, 256'(dut.err_q), 256'(0));
    endtask

    // Main sequence: reset, known vectors, back-pressure, random messages, error and abort
    initial begin
        int nBlocks;
        logic first;
        RST             = 1'b1;
        blk_valid_in    = 1'b0;
        blk_first_in    = 1'b0;
        blk_last_in     = 1'b0;
        digest_ready_in = 1'b0;
        dpGood          = 1'b1;
        curBlock        = '0;
        hModel          = TB_IV;
        modelPending    = 1'b0;
        #2;
        RST = 1'b0;
        #1;
        checkResetOutputs("reset");
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);

        $display("[TB] abc as first=0 block straight after reset");
        applyStimulus(ABC_BLK, 1'b0, 1'b1);
        checkOutput("abcFromResetH", digest_out, ABC_DIGEST);

        $display("[TB] consumer stalls 10 cycles, then handshake with a new abc block");
        holdDigest(10);
        applyStimulus(ABC_BLK, 1'b1, 1'b1);
        checkOutput("abcDigest", digest_out, ABC_DIGEST);

        $display("[TB] empty message");
        applyStimulus(EMPTY_BLK, 1'b1, 1'b1);
        checkOutput("emptyDigest", digest_out, EMPTY_DIGEST);

        $display("[TB] two-block message, second accept at T+66");
        applyStimulus(TWO_BLK1, 1'b1, 1'b0);
        applyStimulus(TWO_BLK2, 1'b0, 1'b1);
        checkOutput("twoBlockDigest", digest_out, TWO_DIGEST);
        releaseDigest();

        $display("[TB] random messages");
        for (int m = 0; m < 6; m++) begin
            nBlocks = $urandom_range(1, 3);
            for (int b = 0; b < nBlocks; b++) begin
                first = (b == 0) ? ($urandom_range(0, 3) != 0) : 1'b0;
                applyStimulus(randBlock(), first, b == nBlocks - 1);
                if ($urandom_range(0, 1) == 1) idleCycles($urandom_range(1, 3));
            end
            holdDigest($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) releaseDigest();
        end

        $display("[TB] datapath drops comp_valid at finalize");
        dpGood = 1'b0;
        applyStimulus(randBlock(), 1'b1, 1'b1);
        checkOutput("errKeepsH", digest_out, TB_IV);
        checkOutput("errSticky", 256'(dut.err_q), 256'(1));
        dpGood = 1'b1;
        releaseDigest();
        idleCycles(2);
        checkOutput("errStillSet", 256'(dut.err_q), 256'(1));

        $display("[TB] reset at round 30");
        curBlock        = ABC_BLK;
        blk_valid_in    = 1'b1;
        blk_first_in    = 1'b1;
        blk_last_in     = 1'b1;
        digest_ready_in = 1'b1;
        for (int k = 1; k <= 31; k++) begin
            @(negedge CLK);
            blk_valid_in    = 1'b0;
            blk_first_in    = 1'b0;
            blk_last_in     = 1'b0;
            digest_ready_in = 1'b0;
        end
        #1;
        checkOutput("abortRoundBefore", 256'(round_out), 256'(30));
        RST = 1'b0;
        #1;
        checkResetOutputs("abort");
        hModel       = TB_IV;
        modelPending = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        idleCycles(3);
        applyStimulus(ABC_BLK, 1'b1, 1'b1);
        checkOutput("abcAfterAbort", digest_out, ABC_DIGEST);
        releaseDigest();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
